// File: rtl/adder_sweep_defs.sv
// Shared constants for the adder sweep controller:
// FSM state encoding and the fail counter width.
package adder_sweep_defs;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } sweep_state_e;

    localparam int FAIL_CNT_W = 16;

endpackage

// File: rtl/sweep_tag_pipe.sv
// Valid/operand tag delay line matching the adder latency.
// DEPTH=0 degenerates to a wire.
module sweep_tag_pipe #(
    parameter int DEPTH = 2,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    if (DEPTH == 0) begin : g_pass
        logic unused_pass;
        assign unused_pass = ^{clk, rst, flush};
        assign out_valid   = in_valid;
        assign out_data    = in_data;
    end else begin : g_pipe
        logic [DEPTH-1:0] vld;
        logic [DW-1:0]    dat [DEPTH];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld <= '0;
                for (int i = 0; i < DEPTH; i++) dat[i] <= '0;
            end else if (flush) begin
                vld <= '0;
            end else begin
                vld[0] <= in_valid;
                dat[0] <= in_data;
                for (int i = 1; i < DEPTH; i++) begin
                    vld[i] <= vld[i-1];
                    dat[i] <= dat[i-1];
                end
            end
        end

        assign out_valid = vld[DEPTH-1];
        assign out_data  = dat[DEPTH-1];
    end

endmodule

// File: rtl/adder_sweep_ctrl.sv
// Exhaustive operand sweep comparing a structural and a
// behavioral adder, with latency-aligned fail capture.
module adder_sweep_ctrl
    import adder_sweep_defs::*;
#(
    parameter int WIDTH   = 14,
    parameter int LATENCY = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  stop_on_fail,
    output logic [WIDTH-1:0]      adder_operand1,
    output logic [WIDTH-1:0]      adder_operand2,
    input  logic [WIDTH:0]        structural_sum,
    input  logic [WIDTH:0]        behavioral_sum,
    output logic                  busy,
    output logic                  done,
    output logic                  test_fail,
    output logic [FAIL_CNT_W-1:0] fail_count,
    output logic [WIDTH-1:0]      first_fail_op1,
    output logic [WIDTH-1:0]      first_fail_op2
);

    localparam int CW  = 2 * WIDTH;
    localparam int DCW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int DL  = (LATENCY > 0) ? LATENCY - 1 : 0;

    sweep_state_e   state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [DCW-1:0] drain_q, drain_d;
    logic           stop_q;

    logic           start_hit;
    logic           abort_hit;
    logic           flush;
    logic           tag_vld;
    logic [CW-1:0]  tag_ops;
    logic           mismatch;
    logic           stop_hit;

    assign abort_hit = abort && (state_q != S_IDLE);
    assign start_hit = start && !abort &&
                       (state_q == S_IDLE || state_q == S_DONE);
    assign mismatch  = tag_vld && (structural_sum != behavioral_sum);
    assign stop_hit  = mismatch && stop_q;
    assign flush     = abort_hit || start_hit || stop_hit;

    sweep_tag_pipe #(
        .DEPTH (LATENCY),
        .DW    (CW)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (state_q == S_RUN),
        .in_data   (cnt_q),
        .out_valid (tag_vld),
        .out_data  (tag_ops)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_hit) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (stop_hit) begin
                    state_d = S_DONE;
                end else if (cnt_q == '1) begin
                    state_d = (LATENCY > 0) ? S_DRAIN : S_DONE;
                    drain_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (stop_hit || drain_q == DCW'(DL)) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_hit) state_d = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
        end
    end

    // Fail record survives abort; only a new start clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stop_q         <= 1'b0;
            test_fail      <= 1'b0;
            fail_count     <= '0;
            first_fail_op1 <= '0;
            first_fail_op2 <= '0;
        end else if (start_hit) begin
            stop_q         <= stop_on_fail;
            test_fail      <= 1'b0;
            fail_count     <= '0;
            first_fail_op1 <= '0;
            first_fail_op2 <= '0;
        end else if (mismatch) begin
            test_fail <= 1'b1;
            if (fail_count != '1) fail_count <= fail_count + 1'b1;
            if (!test_fail) begin
                first_fail_op1 <= tag_ops[WIDTH-1:0];
                first_fail_op2 <= tag_ops[CW-1:WIDTH];
            end
        end
    end

    assign adder_operand1 = cnt_q[WIDTH-1:0];
    assign adder_operand2 = cnt_q[CW-1:WIDTH];
    assign busy = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_adder_sweep_ctrl.sv
// Bench for adder_sweep_ctrl: WIDTH=4 instances at
// LATENCY=2 and LATENCY=0 driven by a fault-injecting adder model.
module tb_adder_sweep_ctrl;

    localparam int W  = 4;
    localparam int NV = 1 << (2 * W);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start2 = 1'b0, start0 = 1'b0;
    logic abort2 = 1'b0, abort0 = 1'b0;
    logic stop_on_fail = 1'b0;

    logic [W-1:0]  a2, b2, a0, b0;
    logic [W:0]    ss2, bs2, ss0, bs0;
    logic          busy2, done2, tf2, busy0, done0, tf0;
    logic [15:0]   fc2, fc0;
    logic [W-1:0]  fa2, fb2, fa0, fb0;
    logic [W-1:0]  a2_d1, b2_d1, a2_d2, b2_d2;

    int fault_kind = 0;
    int tgt_a = 0, tgt_b = 0;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    adder_sweep_ctrl #(.WIDTH(W), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2),
        .stop_on_fail(stop_on_fail),
        .adder_operand1(a2), .adder_operand2(b2),
        .structural_sum(ss2), .behavioral_sum(bs2),
        .busy(busy2), .done(done2), .test_fail(tf2),
        .fail_count(fc2),
        .first_fail_op1(fa2), .first_fail_op2(fb2)
    );

    adder_sweep_ctrl #(.WIDTH(W), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0),
        .stop_on_fail(stop_on_fail),
        .adder_operand1(a0), .adder_operand2(b0),
        .structural_sum(ss0), .behavioral_sum(bs0),
        .busy(busy0), .done(done0), .test_fail(tf0),
        .fail_count(fc0),
        .first_fail_op1(fa0), .first_fail_op2(fb0)
    );

    function automatic bit is_fault(int a, int b);
        case (fault_kind)
            1: return (a == tgt_a) && (b == tgt_b);
            2: return a == 15;
            default: return 1'b0;
        endcase
    endfunction

    // Registered adders with two cycles of latency for dut
    always @(posedge clk) begin
        a2_d1 <= a2; b2_d1 <= b2;
        a2_d2 <= a2_d1; b2_d2 <= b2_d1;
    end

    always_comb begin
        ss2 = {1'b0, a2_d2} + {1'b0, b2_d2};
        bs2 = ss2 + {4'd0, is_fault(int'(a2_d2), int'(b2_d2))};
        ss0 = {1'b0, a0} + {1'b0, b0};
        bs0 = ss0 + {4'd0, is_fault(int'(a0), int'(b0))};
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit m_busy(bit sel);
        return sel ? busy0 : busy2;
    endfunction
    function automatic bit m_done(bit sel);
        return sel ? done0 : done2;
    endfunction

    task automatic chk_outs(input bit sel, input string tag, input int ef,
                            input int ec, input int ea, input int eb);
        chk({tag, "_test_fail"}, sel ? int'(tf0) : int'(tf2), ef);
        chk({tag, "_fail_count"}, sel ? int'(fc0) : int'(fc2), ec);
        chk({tag, "_first_op1"}, sel ? int'(fa0) : int'(fa2), ea);
        chk({tag, "_first_op2"}, sel ? int'(fb0) : int'(fb2), eb);
    endtask

    // Reference: walk vectors in sweep order, compares up to last_idx.
    task automatic model(input int lat, input bit stop, input int last_idx,
                         output int busy_n, output int nf,
                         output int fa, output int fb);
        busy_n = NV + lat;
        nf = 0; fa = 0; fb = 0;
        for (int i = 0; i <= last_idx; i++) begin
            if (is_fault(i % 16, i / 16)) begin
                if (nf == 0) begin
                    fa = i % 16;
                    fb = i / 16;
                end
                nf++;
                if (stop) begin
                    busy_n = i + lat + 1;
                    break;
                end
            end
        end
    endtask

    task automatic run_sweep(input bit sel, input bit stop,
                             output int nbusy);
        stop_on_fail = stop;
        @(negedge clk);
        if (sel) start0 = 1'b1; else start2 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start2 = 1'b0;
        nbusy = 0;
        for (int c = 0; c < 600; c++) begin
            if (m_done(sel)) break;
            if (m_busy(sel)) nbusy++;
            @(posedge clk); #1;
        end
        if (!m_done(sel)) chk("sweep_timeout", 0, 1);
    endtask

    typedef struct {
        bit sel;
        int kind;
        int ta;
        int tb;
        bit stop;
        int e_busy;
        int e_fail;
        int e_cnt;
        int e_a;
        int e_b;
    } vec_t;

    vec_t tbl[6];
    int nb, eb_n, enf, efa, efb;
    bit rs, rstop;

    initial begin
        tbl[0] = '{0, 0, 0, 0, 0, 258, 0, 0, 0, 0};
        tbl[1] = '{0, 1, 3, 5, 0, 258, 1, 1, 3, 5};
        tbl[2] = '{0, 2, 0, 0, 0, 258, 1, 16, 15, 0};
        tbl[3] = '{0, 1, 3, 5, 1, 86, 1, 1, 3, 5};
        tbl[4] = '{1, 0, 0, 0, 0, 256, 0, 0, 0, 0};
        tbl[5] = '{1, 2, 0, 0, 1, 16, 1, 1, 15, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy2), 0);
        chk("rst_done", int'(done2), 0);
        chk("rst_op1", int'(a2), 0);
        chk("rst_op2", int'(b2), 0);
        chk_outs(0, "rst", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 6; k++) begin
            fault_kind = tbl[k].kind;
            tgt_a = tbl[k].ta;
            tgt_b = tbl[k].tb;
            run_sweep(tbl[k].sel, tbl[k].stop, nb);
            chk($sformatf("t%0d_busy_cycles", k), nb, tbl[k].e_busy);
            chk_outs(tbl[k].sel, $sformatf("t%0d", k), tbl[k].e_fail,
                     tbl[k].e_cnt, tbl[k].e_a, tbl[k].e_b);
            repeat (3) @(posedge clk);
            #1;
            chk($sformatf("t%0d_done_hold", k), int'(m_done(tbl[k].sel)), 1);
        end

        for (int k = 0; k < 6; k++) begin
            rs = 1'($urandom_range(0, 1));
            rstop = 1'($urandom_range(0, 1));
            fault_kind = 1;
            tgt_a = $urandom_range(0, 15);
            tgt_b = $urandom_range(0, 15);
            model(rs ? 0 : 2, rstop, NV - 1, eb_n, enf, efa, efb);
            run_sweep(rs, rstop, nb);
            chk($sformatf("r%0d_busy_cycles", k), nb, eb_n);
            chk_outs(rs, $sformatf("r%0d", k), 1, enf, efa, efb);
        end

        // Abort mid-sweep at vector 100 on the latency-2 instance
        fault_kind = 2;
        stop_on_fail = 1'b0;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if ({b2, a2} == 8'd100) break;
            @(posedge clk); #1;
        end
        chk("abort_reach_vec", int'({b2, a2}), 100);
        abort2 = 1'b1;
        @(posedge clk); #1;
        abort2 = 1'b0;
        chk("abort_busy", int'(busy2), 0);
        chk("abort_done", int'(done2), 0);
        model(2, 1'b0, 100 - 2, eb_n, enf, efa, efb);
        chk_outs(0, "abort", 1, enf, efa, efb);
        repeat (5) @(posedge clk);
        #1;
        chk("abort_count_hold", int'(fc2), enf);
        fault_kind = 0;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        chk_outs(0, "restart", 0, 0, 0, 0);
        chk("restart_busy", int'(busy2), 1);
        for (int c = 0; c < 300 && !done2; c++) begin
            @(posedge clk); #1;
        end
        chk("restart_done", int'(done2), 1);

        // Reset pulse mid-sweep on the combinational instance
        fault_kind = 2;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_busy", int'(busy0), 0);
        chk("mrst_done", int'(done0), 0);
        chk("mrst_op1", int'(a0), 0);
        chk("mrst_op2", int'(b0), 0);
        chk_outs(1, "mrst", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        fault_kind = 0;
        run_sweep(1, 1'b0, nb);
        chk("mrst_rerun_busy", nb, 256);
        chk_outs(1, "mrst_rerun", 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
